control_unit: RTL and testbench

Instruction-fetch and sequencing core of the processor: a 7-bit program counter addresses a 128×16 instruction ROM, and an instruction register captures the fetched word. A state machine decodes the IR and drives the datapath control signals (data memory, register file, ALU). It sits between the instruction store and the datapath, and exposes its state, PC and IR for observation.

---
 rtl/control_unit_pkg.sv | 23 ++
 rtl/control_unit_if.sv | 14 +
 rtl/control_unit_fetch.sv | 38 +++
 rtl/control_unit_fsm.sv | 84 ++++++++
 rtl/control_unit.sv | 32 +++
 tb/tb_control_unit.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, opcodes, ALU selects.
package StateDefs;

    typedef enum logic [3:0] {
        Init, Fetch, Decode, NoOp, Load_A, Load_B, Store, Add, Sub, Halt
    } State;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    localparam logic [2:0] ALU_IDLE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    function automatic string state_to_string(State s);
        return s.name();
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Datapath control bundle: the sequencer is master, the data memory / register file / ALU are slaves.
interface control_unit_if;
    logic       D_Wr;
    logic       RF_s;
    logic       RF_W_en;
    logic [7:0] D_Addr;
    logic [3:0] RF_W_Addr;
    logic [3:0] RF_Ra_Addr;
    logic [3:0] RF_Rb_Addr;
    logic [2:0] ALU_s0;

    modport master (output D_Wr, RF_s, RF_W_en, D_Addr, RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, ALU_s0);
    modport slave  (input  D_Wr, RF_s, RF_W_en, D_Addr, RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, ALU_s0);
endinterface

// File: rtl/control_unit_fetch.sv
// Fetch path: program counter, registered-address instruction ROM and instruction register.
module PC (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Clr,
    input  logic       Up,
    output logic [6:0] Addr
);
    // Clear outranks increment; 127 + 1 wraps naturally in 7 bits.
    always_ff @(posedge Clk) begin
        if (Reset || Clr) Addr <= '0;
        else if (Up)      Addr <= Addr + 7'd1;
    end
endmodule

module InstMemory #(
    parameter logic [15:0] INIT [128] = '{default: 16'h0000}
) (
    input  logic [6:0]  Addr,
    input  logic        Clk,
    output logic [15:0] q
);
    // Contents are fixed when the parent elaborates; address is sampled every edge.
    always_ff @(posedge Clk) q <= INIT[Addr];
endmodule

module IR (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ld,
    input  logic [15:0] d,
    output logic [15:0] q
);
    always_ff @(posedge Clk) begin
        if (Reset)   q <= '0;
        else if (ld) q <= d;
    end
endmodule

// File: rtl/control_unit_fsm.sv
// Sequencing FSM: decodes the IR and drives PC/IR strobes and the datapath controls.
module StateMachine
    import StateDefs::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Instr,
    output State        OutState,
    output State        NextState,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    control_unit_if.master bus
);

    always_ff @(posedge Clk) begin
        if (Reset) OutState <= Init;
        else       OutState <= NextState;
    end

    always_comb begin
        NextState = Init;
        case (OutState)
            Init:   NextState = Fetch;
            Fetch:  NextState = Decode;
            Decode: begin
                case (Instr[15:12])
                    OP_STORE: NextState = Store;
                    OP_LOAD:  NextState = Load_A;
                    OP_ADD:   NextState = Add;
                    OP_SUB:   NextState = Sub;
                    OP_HALT:  NextState = Halt;
                    default:  NextState = NoOp;
                endcase
            end
            Load_A:                         NextState = Load_B;
            NoOp, Load_B, Store, Add, Sub:  NextState = Fetch;
            Halt:                           NextState = Halt;
            default:                        NextState = Init;
        endcase
    end

    always_comb begin
        PC_clr         = 1'b0;
        PC_up          = 1'b0;
        IR_ld          = 1'b0;
        bus.D_Wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_en    = 1'b0;
        bus.D_Addr     = '0;
        bus.RF_W_Addr  = '0;
        bus.RF_Ra_Addr = '0;
        bus.RF_Rb_Addr = '0;
        bus.ALU_s0     = ALU_IDLE;
        case (OutState)
            Init: PC_clr = 1'b1;
            Fetch: begin
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            // Load spans two cycles so the data memory read settles before the write.
            Load_A, Load_B: begin
                bus.D_Addr    = Instr[11:4];
                bus.RF_s      = 1'b1;
                bus.RF_W_Addr = Instr[3:0];
                bus.RF_W_en   = (OutState == Load_B);
            end
            Store: begin
                bus.D_Addr     = Instr[7:0];
                bus.RF_Ra_Addr = Instr[11:8];
                bus.D_Wr       = 1'b1;
            end
            Add, Sub: begin
                bus.RF_Ra_Addr = Instr[11:8];
                bus.RF_Rb_Addr = Instr[7:4];
                bus.RF_W_Addr  = Instr[3:0];
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = (OutState == Sub) ? ALU_SUB : ALU_ADD;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Top of the instruction-fetch/sequencing core; wires PC, ROM, IR and the FSM together.
module control_unit
    import StateDefs::*;
#(
    parameter logic [15:0] ROM_INIT [128] = '{default: 16'h0000}
) (
    input  logic        Clk,
    input  logic        Reset,
    control_unit_if.master dp,
    output State        OutState,
    output State        NextState,
    output logic [15:0] IR_Out,
    output logic [6:0]  PC_Out
);

    logic        pc_clr, pc_up, ir_ld;
    logic [15:0] rom_q;

    PC u_pc (.Clk(Clk), .Reset(Reset), .Clr(pc_clr), .Up(pc_up), .Addr(PC_Out));

    InstMemory #(.INIT(ROM_INIT)) u_rom (.Addr(PC_Out), .Clk(Clk), .q(rom_q));

    IR u_ir (.Clk(Clk), .Reset(Reset), .ld(ir_ld), .d(rom_q), .q(IR_Out));

    StateMachine u_sm (
        .Clk(Clk), .Reset(Reset), .Instr(IR_Out),
        .OutState(OutState), .NextState(NextState),
        .PC_clr(pc_clr), .PC_up(pc_up), .IR_ld(ir_ld),
        .bus(dp)
    );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: expected per-cycle trace derived from the program, random mid-run resets.
module tb_control_unit;
    import StateDefs::*;

    typedef logic [15:0] rom_t [128];

    localparam rom_t PROG = '{
        0: 16'h21B3, 1: 16'h1523, 2: 16'h3124, 3: 16'h4567, 4: 16'hF000,
        5: 16'h2FE0, 6: 16'h10FF, 7: 16'h4FFF, 8: 16'h6123, 9: 16'h3000,
        10: 16'h9ABC, 11: 16'h0ABC, 12: 16'h2007, 13: 16'h1E80, 14: 16'h3ABC,
        15: 16'h5000, default: 16'h0000};
    localparam rom_t ZERO = '{default: 16'h0000};

    typedef struct {
        State        st;
        State        nx;
        logic [25:0] ctl;
        logic [6:0]  pc;
        logic [15:0] ir;
    } cyc_t;

    logic Clk, Reset, Reset_w;
    State st0, nx0, st1, nx1;
    logic [15:0] ir0, ir1;
    logic [6:0]  pc0, pc1;
    int vectors = 0;
    int miscompares = 0;
    cyc_t trace[$];

    control_unit_if bus0 ();
    control_unit_if bus1 ();

    control_unit #(.ROM_INIT(PROG)) dut (
        .Clk(Clk), .Reset(Reset), .dp(bus0),
        .OutState(st0), .NextState(nx0), .IR_Out(ir0), .PC_Out(pc0));

    control_unit #(.ROM_INIT(ZERO)) dut_w (
        .Clk(Clk), .Reset(Reset_w), .dp(bus1),
        .OutState(st1), .NextState(nx1), .IR_Out(ir1), .PC_Out(pc1));

    // {D_Wr, RF_s, RF_W_en, D_Addr, RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, ALU_s0}
    wire [25:0] ctl0 = {bus0.D_Wr, bus0.RF_s, bus0.RF_W_en, bus0.D_Addr,
                        bus0.RF_W_Addr, bus0.RF_Ra_Addr, bus0.RF_Rb_Addr, bus0.ALU_s0};
    wire [25:0] ctl1 = {bus1.D_Wr, bus1.RF_s, bus1.RF_W_en, bus1.D_Addr,
                        bus1.RF_W_Addr, bus1.RF_Ra_Addr, bus1.RF_Rb_Addr, bus1.ALU_s0};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] exp_ctrl(State s, logic [15:0] w);
        case (s)
            Load_A: return {3'b010, w[11:4], w[3:0], 8'h00, 3'd0};
            Load_B: return {3'b011, w[11:4], w[3:0], 8'h00, 3'd0};
            Store:  return {3'b100, w[7:0], 4'h0, w[11:8], 4'h0, 3'd0};
            Add:    return {3'b001, 8'h00, w[3:0], w[11:8], w[7:4], 3'd1};
            Sub:    return {3'b001, 8'h00, w[3:0], w[11:8], w[7:4], 3'd2};
            default: return 26'd0;
        endcase
    endfunction

    function automatic void push(State s, State n, logic [25:0] c, logic [6:0] p, logic [15:0] r);
        cyc_t e;
        e.st = s; e.nx = n; e.ctl = c; e.pc = p; e.ir = r;
        trace.push_back(e);
    endfunction

    // Expected cycle sequence from reset release, instruction by instruction.
    function automatic void build_trace(input rom_t rom, input int max_instr);
        logic [15:0] prev;
        logic [15:0] w;
        logic [6:0]  a;
        State        ex[$];
        prev = 16'h0000;
        trace.delete();
        for (int k = 0; k < max_instr; k++) begin
            a = 7'(k % 128);
            w = rom[a];
            ex.delete();
            case (w[15:12])
                4'h1: ex.push_back(Store);
                4'h2: begin ex.push_back(Load_A); ex.push_back(Load_B); end
                4'h3: ex.push_back(Add);
                4'h4: ex.push_back(Sub);
                4'h5: ex.push_back(Halt);
                default: ex.push_back(NoOp);
            endcase
            push(Fetch, Decode, 26'd0, a, prev);
            push(Decode, ex[0], 26'd0, a + 7'd1, w);
            if (ex[0] == Halt) begin
                for (int h = 0; h < 100; h++) push(Halt, Halt, 26'd0, a + 7'd1, w);
                break;
            end
            for (int i = 0; i < ex.size(); i++)
                push(ex[i], (i + 1 < ex.size()) ? ex[i + 1] : Fetch,
                     exp_ctrl(ex[i], w), a + 7'd1, w);
            prev = w;
        end
    endfunction

    task automatic observe(input int d, output State s, output State n,
                           output logic [6:0] p, output logic [15:0] r, output logic [25:0] c);
        if (d == 0) begin s = st0; n = nx0; p = pc0; r = ir0; c = ctl0; end
        else        begin s = st1; n = nx1; p = pc1; r = ir1; c = ctl1; end
    endtask

    task automatic walk(input int d, input int n);
        State s, nx;
        logic [6:0] p;
        logic [15:0] r;
        logic [25:0] c;
        for (int i = 0; i < n; i++) begin
            tick();
            observe(d, s, nx, p, r, c);
            chk($sformatf("d%0d.c%0d.%s.state", d, i, state_to_string(trace[i].st)), 32'(s), 32'(trace[i].st));
            chk($sformatf("d%0d.c%0d.next", d, i), 32'(nx), 32'(trace[i].nx));
            chk($sformatf("d%0d.c%0d.pc", d, i), 32'(p), 32'(trace[i].pc));
            chk($sformatf("d%0d.c%0d.ir", d, i), 32'(r), 32'(trace[i].ir));
            chk($sformatf("d%0d.c%0d.ctrl", d, i), 32'(c), 32'(trace[i].ctl));
        end
    endtask

    task automatic chk_reset(input int d, input string tag);
        State s, nx;
        logic [6:0] p;
        logic [15:0] r;
        logic [25:0] c;
        observe(d, s, nx, p, r, c);
        chk({tag, ".state"}, 32'(s), 32'(Init));
        chk({tag, ".next"}, 32'(nx), 32'(Fetch));
        chk({tag, ".pc"}, 32'(p), 32'd0);
        chk({tag, ".ir"}, 32'(r), 32'd0);
        chk({tag, ".ctrl"}, 32'(c), 32'd0);
    endtask

    initial begin
        int n;
        Reset   = 1'b1;
        Reset_w = 1'b1;
        build_trace(PROG, 64);

        tick(); tick();
        chk_reset(0, "por");

        // Full program run into HALT, then 100 frozen cycles.
        Reset = 1'b0;
        walk(0, trace.size());
        Reset = 1'b1;
        tick();
        chk_reset(0, "halt_rst");

        // Reset dropped in at random points mid-instruction.
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, trace.size());
            Reset = 1'b0;
            walk(0, n);
            Reset = 1'b1;
            tick();
            chk_reset(0, $sformatf("mid_rst%0d", t));
            if ($urandom_range(0, 1) == 1) begin
                tick();
                chk_reset(0, $sformatf("mid_rst%0d_hold", t));
            end
        end

        // All-NOOP ROM long enough for the PC to wrap 127 -> 0.
        build_trace(ZERO, 140);
        chk_reset(1, "wrap_por");
        Reset_w = 1'b0;
        walk(1, trace.size());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
